// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg: shared states, select-width helper and error-mode encodings
package mux_pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_e;
  localparam int ZOE_CH0 = 0;
  localparam int ZOE_ZERO = 1;
  function automatic int sel_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_skid_buf.sv
// mux_skid_buf: 2-entry skid buffer with registered d_ready
module mux_skid_buf import mux_pipe_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [1:0]       occupancy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic ready_q, ready_d, acc, pop;
  assign acc = d_valid & ready_q;
  assign pop = q_valid & q_ready;
  assign q_valid = state_q != ST_EMPTY;
  assign q = main_q;
  assign d_ready = ready_q;
  assign occupancy = state_q;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    unique case (state_q)
      ST_EMPTY: if (acc) begin
        state_d = ST_ONE;
        main_d = d;
      end
      ST_ONE: if (acc && pop) main_d = d;
      else if (acc) begin
        state_d = ST_FULL;
        skid_d = d;
      end else if (pop) state_d = ST_EMPTY;
      ST_FULL: if (pop) begin
        state_d = ST_ONE;
        main_d = skid_q;
      end
      default: state_d = ST_EMPTY;
    endcase
    ready_d = state_d != ST_FULL;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: registered N:1 selector with valid/ready handshake and sticky range error
module mux_pipe_stage import mux_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 2,
  parameter int ZERO_ON_ERR = ZOE_ZERO,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy,
  output logic                    err,
  input  logic                    err_clr
);
  logic [WIDTH-1:0] sel_data;
  logic bad_sel, err_q, err_d;
  always_comb begin
    sel_data = (ZERO_ON_ERR == ZOE_ZERO) ? '0 : in_data[WIDTH-1:0];
    for (int k = 0; k < NUM_IN; k++) if (int'(in_sel) == k) sel_data = in_data[k*WIDTH +: WIDTH];
    bad_sel = int'(in_sel) >= NUM_IN;
    err_d = (in_valid & in_ready & bad_sel) | (err_q & ~err_clr);
  end
  always_ff @(posedge clk) begin
    if (res) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err = err_q;
  mux_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk(clk), .res(res),
    .d(sel_data), .d_valid(in_valid), .d_ready(in_ready),
    .q(out_data), .q_valid(out_valid), .q_ready(out_ready),
    .occupancy(occupancy)
  );
endmodule

// File: tb/tb_mux_pipe_stage.sv
// tb_mux_pipe_stage: directed checks on a 4-input and a 3-input instance
module tb_mux_pipe_stage;
  logic clk = 0, res = 1;
  always #5 clk = ~clk;
  logic [127:0] d4;
  logic [1:0] s4, occ4;
  logic v4, ir4, ov4, r4, e4, clr4;
  logic [31:0] o4;
  logic [95:0] d3;
  logic [1:0] s3, occ3;
  logic v3, ir3, ov3, r3, e3, clr3;
  logic [31:0] o3;
  int checks = 0, failures = 0;
  mux_pipe_stage #(.WIDTH(32), .NUM_IN(4), .ZERO_ON_ERR(1)) u4 (
    .clk(clk), .res(res), .in_data(d4), .in_sel(s4), .in_valid(v4), .in_ready(ir4),
    .out_data(o4), .out_valid(ov4), .out_ready(r4), .occupancy(occ4), .err(e4), .err_clr(clr4));
  mux_pipe_stage #(.WIDTH(32), .NUM_IN(3), .ZERO_ON_ERR(1)) u3 (
    .clk(clk), .res(res), .in_data(d3), .in_sel(s3), .in_valid(v3), .in_ready(ir3),
    .out_data(o3), .out_valid(ov3), .out_ready(r3), .occupancy(occ3), .err(e3), .err_clr(clr3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; s4 = 0; v4 = 1; r4 = 1; clr4 = 0;
    d3 = {32'h7, 32'h6, 32'h5}; s3 = 0; v3 = 0; r3 = 1; clr3 = 0;
    repeat (3) tick();
    chk("rst_out_valid", ov4, 0);
    chk("rst_in_ready", ir4, 0);
    chk("rst_occ", occ4, 0);
    chk("rst_err", e4, 0);
    chk("rst_out_data", o4, 0);
    res = 0;
    tick();
    chk("rel_in_ready", ir4, 1);
    chk("rel_out_valid", ov4, 0);
    for (int i = 0; i < 4; i++) begin
      s4 = 2'(i); v4 = 1;
      tick();
      chk($sformatf("stream_data%0d", i), o4, 32'hA0 + i);
      chk($sformatf("stream_valid%0d", i), ov4, 1);
      chk($sformatf("stream_ready%0d", i), ir4, 1);
    end
    v4 = 0;
    tick();
    chk("stream_drain_valid", ov4, 0);
    chk("stream_drain_occ", occ4, 0);
    r4 = 0; v4 = 1; s4 = 0; d4[31:0] = 32'h11;
    tick();
    chk("bp_occ1", occ4, 1);
    chk("bp_data1", o4, 32'h11);
    d4[31:0] = 32'h22;
    tick();
    chk("bp_occ2", occ4, 2);
    chk("bp_ready0", ir4, 0);
    chk("bp_hold", o4, 32'h11);
    d4[31:0] = 32'h33;
    tick();
    chk("bp_full_ignore_occ", occ4, 2);
    chk("bp_full_hold", o4, 32'h11);
    chk("bp_full_valid", ov4, 1);
    v4 = 0; r4 = 1;
    tick();
    chk("bp_pop1_data", o4, 32'h22);
    chk("bp_pop1_occ", occ4, 1);
    chk("bp_pop1_ready", ir4, 1);
    tick();
    chk("bp_pop2_occ", occ4, 0);
    chk("bp_pop2_valid", ov4, 0);
    r3 = 0; s3 = 3; v3 = 1;
    tick();
    chk("rng_data_zero", o3, 0);
    chk("rng_valid", ov3, 1);
    chk("rng_err", e3, 1);
    v3 = 0; r3 = 1;
    tick();
    chk("rng_err_held", e3, 1);
    chk("rng_occ", occ3, 0);
    clr3 = 1; v3 = 1; s3 = 3;
    tick();
    chk("rng_set_wins", e3, 1);
    chk("rng_data_zero2", o3, 0);
    v3 = 0;
    tick();
    chk("rng_clr", e3, 0);
    clr3 = 0; s3 = 2; v3 = 1;
    tick();
    chk("rng_good_data", o3, 32'h7);
    chk("rng_good_noerr", e3, 0);
    v3 = 0;
    tick();
    r4 = 0; v4 = 1; s4 = 1; d4[63:32] = 32'h55;
    tick();
    d4[63:32] = 32'h66;
    tick();
    chk("mid_full_occ", occ4, 2);
    v4 = 0; res = 1;
    tick();
    chk("mid_rst_occ", occ4, 0);
    chk("mid_rst_valid", ov4, 0);
    chk("mid_rst_ready", ir4, 0);
    res = 0; r4 = 1;
    tick();
    chk("mid_rel_valid", ov4, 0);
    chk("mid_rel_ready", ir4, 1);
    tick();
    chk("mid_no_ghost", ov4, 0);
    chk("mid_no_ghost_data", o4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
